// File: rtl/gate_truth_sequencer_pkg.sv
// Shared definitions for the gate truth-table sequencer and its sibling gate labs.
package gate_truth_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    // Two-input truth tables, bit k = expected output for input code k.
    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

endpackage

// File: rtl/gate_truth_sequencer_settle_timer.sv
// Down-counter used for the per-code settle wait; zero_o flags the final wait cycle.
module settle_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// Self-test controller: walks every input code of an external gate and checks it against TRUTH_TABLE.
module gate_truth_sequencer
    import gate_truth_sequencer_pkg::*;
#(
    parameter int unsigned            N_IN        = 2,
    parameter int unsigned            SETTLE      = 2,
    parameter logic [(1<<N_IN)-1:0]   TRUTH_TABLE = TT_OR2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_idx
);

    localparam int unsigned NV = 1 << N_IN;
    localparam int unsigned CW = N_IN + 1;
    localparam int unsigned TW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    // Loading SETTLE-1 makes the zero flag mark the last of SETTLE wait cycles.
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);

    seq_state_e      state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [CW-1:0]   err_q, err_d;
    logic [N_IN-1:0] ffi_q, ffi_d;
    logic            pass_q, pass_d;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;
    logic last_code;
    logic mismatch;

    assign last_code = (idx_q == N_IN'(NV - 1));
    assign mismatch  = (gate_out != TRUTH_TABLE[idx_q]);

    settle_timer #(
        .W (TW)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (SETTLE_LD),
        .dec_i      (timer_dec),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_WAIT;
            ST_WAIT:   if (abort) state_d = ST_IDLE;
                       else if (timer_zero) state_d = ST_SAMPLE;
            ST_SAMPLE: if (abort) state_d = ST_IDLE;
                       else if (last_code) state_d = ST_DONE;
                       else state_d = ST_WAIT;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_WAIT) || (state_q == ST_SAMPLE);
        done       = (state_q == ST_DONE);
        timer_dec  = (state_q == ST_WAIT);
        timer_load = ((state_q == ST_IDLE) && start) ||
                     ((state_q == ST_SAMPLE) && !abort && !last_code);
    end

    // Abort wins over the compare, so an aborted sample never touches the error record.
    always_comb begin
        idx_d  = idx_q;
        err_d  = err_q;
        ffi_d  = ffi_q;
        pass_d = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d  = '0;
                    err_d  = '0;
                    ffi_d  = '0;
                    pass_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    idx_d  = '0;
                    pass_d = 1'b0;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    idx_d  = '0;
                    pass_d = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_d = err_q + CW'(1);
                        if (err_q == '0) ffi_d = idx_q;
                    end
                    if (last_code) pass_d = (err_d == '0);
                    else idx_d = idx_q + N_IN'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            err_q  <= '0;
            ffi_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            err_q  <= err_d;
            ffi_q  <= ffi_d;
            pass_q <= pass_d;
        end
    end

    assign gate_in        = idx_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Bench for gate_truth_sequencer: a 2-input instance with a swappable gate model and a 3-input OR instance.
module tb_gate_truth_sequencer;
    import gate_truth_sequencer_pkg::*;

    localparam int GM_OR = 0, GM_AND = 1, GM_ONE = 2, GM_XOR = 3, GM_ZERO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, gate_out;
    logic [1:0] gate_in, ffi;
    logic       busy, done, pass;
    logic [2:0] err_count;
    int         gmode;

    logic       start2, abort2, gate_out2;
    logic [2:0] gate_in2, ffi2;
    logic       busy2, done2, pass2;
    logic [3:0] err2;

    always_comb begin
        case (gmode)
            GM_OR:   gate_out = |gate_in;
            GM_AND:  gate_out = &gate_in;
            GM_ONE:  gate_out = 1'b1;
            GM_XOR:  gate_out = ^gate_in;
            default: gate_out = 1'b0;
        endcase
    end
    assign gate_out2 = |gate_in2;

    gate_truth_sequencer #(.N_IN(2), .SETTLE(2), .TRUTH_TABLE(4'b1110)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_in(gate_in),
        .gate_out(gate_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_idx(ffi)
    );

    gate_truth_sequencer #(.N_IN(3), .SETTLE(1), .TRUTH_TABLE(8'hFE)) dut3 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .gate_in(gate_in2),
        .gate_out(gate_out2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_fail_idx(ffi2)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int lat;
        int err;
        int ffi;
        int pass_v;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int mode;
        int err;
        int ffi;
        int pass_v;
    } vec_t;
    vec_t vecs[5];

    // Launches one run on the 2-input DUT and checks the outcome against the scoreboard head.
    task automatic run_dut1(input bit walk_chk);
        int   edges;
        exp_t e;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            if (walk_chk) chk("walk_gate_in", int'(gate_in), edges / 3);
            @(posedge clk); #1;
            edges++;
        end
        chk("done_seen", int'(done === 1'b1), 1);
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("latency", edges, e.lat);
            chk("err_count", int'(err_count), e.err);
            chk("first_fail_idx", int'(ffi), e.ffi);
            chk("pass", int'(pass), e.pass_v);
            @(posedge clk); #1;
            chk("done_one_cycle", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
            chk("hold_err", int'(err_count), e.err);
            chk("hold_pass", int'(pass), e.pass_v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        int done_at;
        int edges;

        vecs[0] = '{GM_OR,   0, 0, 1};
        vecs[1] = '{GM_AND,  2, 1, 0};
        vecs[2] = '{GM_ONE,  1, 0, 0};
        vecs[3] = '{GM_XOR,  1, 3, 0};
        vecs[4] = '{GM_ZERO, 3, 1, 0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; gmode = GM_OR;
        start2 = 1'b0; abort2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gate_in", int'(gate_in), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_count), 0);
        chk("rst_ffi", int'(ffi), 0);
        chk("rst_busy3", int'(busy2), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table runs, each launched in the IDLE cycle right after the previous DONE.
        foreach (vecs[i]) begin
            gmode = vecs[i].mode;
            exp_q.push_back('{12, vecs[i].err, vecs[i].ffi, vecs[i].pass_v});
            run_dut1(i == 0);
        end

        // abort in IDLE: no effect on the held results.
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("idle_abort_busy", int'(busy), 0);
        chk("idle_abort_err", int'(err_count), 3);

        // Abort during SAMPLE of code 10 with an AND gate: code 01 counted, code 10 discarded.
        gmode = GM_AND;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("abort_pre_gate_in", int'(gate_in), 2);
        chk("abort_pre_err", int'(err_count), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_gate_in", int'(gate_in), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass", int'(pass), 0);
        chk("abort_err_hold", int'(err_count), 1);
        chk("abort_ffi_hold", int'(ffi), 1);
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        gmode = GM_OR;
        exp_q.push_back('{12, 0, 0, 1});
        run_dut1(1'b0);

        // Reset mid-WAIT of code 01 with a stuck-at-1 gate (one error already logged).
        gmode = GM_ONE;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_gate_in", int'(gate_in), 1);
        chk("mid_err", int'(err_count), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_gate_in", int'(gate_in), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_pass", int'(pass), 0);
        chk("mrst_err", int'(err_count), 0);
        chk("mrst_ffi", int'(ffi), 0);
        ndone = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mrst_no_done", ndone, 0);

        // start+abort together in IDLE (start wins), then extra start pulses while busy and in DONE.
        gmode = GM_OR;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_beats_abort", int'(busy), 1);
        ndone = 0;
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            start = (k == 3 || k == 7 || k == 13) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = k;
            end
        end
        start = 1'b0;
        chk("one_done_per_start", ndone, 1);
        chk("busy_start_latency", done_at, 12);
        chk("busy_start_idle", int'(busy), 0);
        chk("busy_start_pass", int'(pass), 1);

        // 3-input OR, SETTLE=1.
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        edges = 0;
        while (done2 !== 1'b1 && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("n3_latency", edges, 16);
        chk("n3_pass", int'(pass2), 1);
        chk("n3_err", int'(err2), 0);
        chk("n3_gate_in_last", int'(gate_in2), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
